fifo_drain_ctrl: RTL and testbench
==================================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, FIFO word and AXI write-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter BURST_LEN, default 8, beats per full burst (power of 2, 2..16).
REQ-004 SHALL have parameter BASE_ADDR, default 0, start of DDR ring region (burst-aligned).
REQ-005 SHALL have parameter REGION_BYTES, default 4096, ring size (multiple of BURST_LEN*DATA_WIDTH/8).
REQ-006 SHALL have parameter TIMEOUT, default 256, idle cycles before partial flush.
REQ-007 Ports SHALL be as follows.
- rclk  in  1: sole clock, FIFO read domain.
- rrst  in  1: asynchronous active-low reset.
- enable  in  1: drain permitted.
- fifo_empty  in  1: FIFO empty flag.
- fifo_rdata  in  DATA_WIDTH: FIFO read data.
- fifo_r_en  out  1: FIFO read strobe.
- awaddr  out  ADDR_WIDTH; awlen  out  8; awvalid  out  1; awready  in  1: AXI write address.
- wdata  out  DATA_WIDTH; wlast  out  1; wvalid  out  1; wready  in  1: AXI write data.
- bresp  in  2; bvalid  in  1; bready  out  1: AXI write response.
- busy  out  1: state != IDLE.
- err  out  1: sticky, set on bresp != 0.

Function
REQ-008 FSM SHALL have states IDLE, FILL, ADDR, DATA, RESP.
REQ-009 IDLE->FILL SHALL occur when enable=1 and fifo_empty=0.
REQ-010 In FILL, fifo_r_en SHALL assert only when fifo_empty=0 and issued reads < BURST_LEN.
REQ-011 fifo_rdata SHALL be captured into the internal BURST_LEN-entry buffer exactly 1 cycle after each fifo_r_en.
REQ-012 FILL->ADDR SHALL occur once BURST_LEN words are captured; no read SHALL be outstanding on that transition.
REQ-013 In ADDR, awvalid=1, awaddr=current pointer, awlen=captured count-1; ADDR->DATA on awvalid&&awready.
REQ-014 awaddr, awlen and awvalid SHALL hold stable until the handshake completes.
REQ-015 In DATA, beats SHALL be presented from buffer index 0 upward, one per wvalid&&wready.
REQ-016 wdata SHALL hold stable while wvalid=1 and wready=0.
REQ-017 wlast SHALL be 1 on the final beat only; DATA->RESP follows the final handshake.
REQ-018 In RESP, bready=1; RESP->IDLE on bvalid; err SHALL be set if bresp != 0.
REQ-019 Pointer SHALL advance by count*DATA_WIDTH/8 after each B response.
REQ-020 Pointer SHALL wrap to BASE_ADDR when it reaches BASE_ADDR+REGION_BYTES.
REQ-021 enable deasserted outside IDLE SHALL NOT abort; the current burst completes and the FSM then stays in IDLE.
REQ-022 At most one burst SHALL be outstanding; awvalid and wvalid SHALL never be asserted together.

Reset
REQ-023 On rrst=0, asynchronously: state=IDLE, pointer=BASE_ADDR, count=0, timeout counter=0, err=0.
REQ-024 On rrst=0, asynchronously, all outputs 0, including fifo_r_en, awvalid, wvalid, bready, busy, awaddr, awlen, wdata and wlast.
REQ-025 Reset mid-burst SHALL discard buffered data; no AXI signal may remain asserted.

Configuration
REQ-026 With FLUSH_TIMEOUT_EN defined, FILL SHALL count consecutive cycles with fifo_empty=1 and count>=1.
REQ-027 With FLUSH_TIMEOUT_EN defined, reaching TIMEOUT SHALL force FILL->ADDR with awlen=count-1.
REQ-028 With FLUSH_TIMEOUT_EN defined, the timeout counter SHALL clear on any read.
REQ-029 Without FLUSH_TIMEOUT_EN, FILL SHALL wait indefinitely for a full burst, and awlen SHALL always be BURST_LEN-1.

Verification
REQ-030 Scenario: 8 words 0x11..0x88, awready/wready tied 1, bresp=0 -> awaddr=0x0, awlen=7, wdata 0x11..0x88 in order, wlast on 0x88, busy drops after bvalid.
REQ-031 Scenario: wready toggling 1/0 each cycle -> wdata stable during stalls, exactly 8 beats, no duplicates.
REQ-032 Scenario: 129 bursts, default params -> awaddr sequence 0x0,0x20,...,0xFE0, then 0x0 on burst 129.
REQ-033 Scenario: bresp=2 on burst 1 -> err=1 and remains 1 through later bresp=0 bursts until rrst.
REQ-034 Scenario: FLUSH_TIMEOUT_EN, 3 words then empty -> awlen=2 issued 256 cycles after last read, wlast on beat 3, pointer +12.
REQ-035 Scenario: rrst asserted during DATA beat 4 -> all outputs 0 immediately; after release, awaddr restarts at 0x0.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : Drains a read-side FIFO into a DDR ring buffer using AXI
//               write bursts. Collects a burst worth of words into a local
//               buffer, then issues AW, W beats and waits for B before the
//               next burst. The ring pointer wraps at BASE_ADDR+REGION_BYTES.
//               Optional macro FLUSH_TIMEOUT_EN: flush a partial burst after
//               TIMEOUT consecutive idle cycles with at least one word held.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned REGION_BYTES = 4096,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned c_CW    = $clog2(BURST_LEN + 1);
    localparam int unsigned c_IW    = $clog2(BURST_LEN);
    localparam int unsigned c_BYTES = DATA_WIDTH / 8;
    localparam logic [c_CW-1:0]     c_BURST    = c_CW'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0] c_RING_END = (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(REGION_BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [c_CW-1:0]         r_count;    // words captured into the buffer
    logic [c_CW-1:0]         r_issued;   // FIFO reads issued this burst
    logic                    r_rd_pend;  // a read was issued last cycle
    logic [c_CW-1:0]         r_beat;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_buf [BURST_LEN];
    logic [ADDR_WIDTH:0]     w_ptr_sum;
    logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
    logic                    w_full;
    logic                    w_flush;

`ifdef FLUSH_TIMEOUT_EN
    localparam int unsigned c_TW = $clog2(TIMEOUT + 1);
    logic [c_TW-1:0] r_tmo;

    // The final idle cycle that brings the counter up to TIMEOUT triggers the flush.
    assign w_flush = fifo_empty && (r_count != '0) && !r_rd_pend && (r_tmo == c_TW'(TIMEOUT - 1));
`else
    assign w_flush = 1'b0;
`endif

    // Burst is complete when the last outstanding read is captured this cycle.
    assign w_full = r_rd_pend && (r_count == c_BURST - c_CW'(1));

    // Ring pointer advance with wrap back to the region base.
    assign w_ptr_sum = {1'b0, r_ptr} + ((ADDR_WIDTH+1)'(r_count) * (ADDR_WIDTH+1)'(c_BYTES));
    assign w_ptr_nxt = (w_ptr_sum >= c_RING_END) ? ADDR_WIDTH'(BASE_ADDR) : w_ptr_sum[ADDR_WIDTH-1:0];

    assign busy = (r_state != S_IDLE);
    assign err  = r_err;

    // State register.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; all AXI outputs are zero outside their phase.
    always_comb begin
        w_state_nxt = r_state;
        fifo_r_en   = 1'b0;
        awvalid     = 1'b0;
        awaddr      = '0;
        awlen       = '0;
        wvalid      = 1'b0;
        wdata       = '0;
        wlast       = 1'b0;
        bready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                fifo_r_en = !fifo_empty && (r_issued < c_BURST);
                if (w_full || w_flush) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                awvalid = 1'b1;
                awaddr  = r_ptr;
`ifdef FLUSH_TIMEOUT_EN
                awlen   = 8'(r_count - c_CW'(1));
`else
                awlen   = 8'(BURST_LEN - 1);
`endif
                if (awready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                wvalid = 1'b1;
                wdata  = r_buf[r_beat[c_IW-1:0]];
                wlast  = (r_beat == r_count - c_CW'(1));
                if (wready && wlast) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: read/capture counters, beat index, pointer and error flag.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_ptr     <= ADDR_WIDTH'(BASE_ADDR);
            r_count   <= '0;
            r_issued  <= '0;
            r_rd_pend <= 1'b0;
            r_beat    <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_rd_pend <= fifo_r_en;
                    if (fifo_r_en) begin
                        r_issued <= r_issued + c_CW'(1);
                    end
                    if (r_rd_pend) begin
                        r_count <= r_count + c_CW'(1);
                    end
                end
                S_ADDR: begin
                    r_beat <= '0;
                end
                S_DATA: begin
                    if (wready) begin
                        r_beat <= r_beat + c_CW'(1);
                    end
                end
                S_RESP: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_ptr    <= w_ptr_nxt;
                        r_count  <= '0;
                        r_issued <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Capture FIFO data one cycle after each read strobe; contents need no reset.
    always_ff @(posedge rclk) begin
        if ((r_state == S_FILL) && r_rd_pend) begin
            r_buf[r_count[c_IW-1:0]] <= fifo_rdata;
        end
    end

`ifdef FLUSH_TIMEOUT_EN
    // Idle counter: consecutive empty cycles while holding a partial burst.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_tmo <= '0;
        end else if ((r_state != S_FILL) || fifo_r_en) begin
            r_tmo <= '0;
        end else if (fifo_empty && (r_count != '0) && (r_tmo != c_TW'(TIMEOUT))) begin
            r_tmo <= r_tmo + c_TW'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_ctrl
// Description : Directed self-checking bench for fifo_drain_ctrl with a
//               FIFO model and a simple AXI write slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_ctrl;

    logic        rclk = 1'b0;
    logic        rrst = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_rdata = '0;
    logic        fifo_r_en;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int mon_err  = 0;

    // FIFO model: writes by the stimulus tasks, reads by the DUT strobe.
    logic [31:0] mem [1024];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] cap [16];

    assign fifo_empty = (wr_cnt == rd_cnt);

    fifo_drain_ctrl dut (
        .rclk(rclk), .rrst(rrst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy(busy), .err(err)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (fifo_r_en) begin
            fifo_rdata <= mem[rd_cnt % 1024];
            rd_cnt     <= rd_cnt + 1;
        end
    end

    // Protocol monitor: AW/W overlap or reading an empty FIFO.
    always @(negedge rclk) begin
        if (rrst && awvalid && wvalid) mon_err++;
        if (rrst && fifo_r_en && fifo_empty) mon_err++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic push(input logic [31:0] w);
        mem[wr_cnt % 1024] = w;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst = 1'b0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        repeat (2) @(negedge rclk);
        rrst = 1'b1;
        @(negedge rclk);
    endtask

    // AXI slave: takes one burst, stores accepted beats in cap[]. wmode 0 = wready
    // always 1, 1 = toggling starting low. abort_beat >= 0 returns when that beat
    // index is presented, without accepting it.
    task automatic collect(input int wmode, input logic [1:0] resp, input int abort_beat,
                           output logic [31:0] addr, output logic [7:0] len, output int nb,
                           output int lastpos, output int stall_err, output int ok);
        logic [31:0] prev;
        bit stalled, done;
        int cyc;
        ok = 0; nb = 0; lastpos = 0; stall_err = 0; addr = '0; len = '0;
        prev = '0; stalled = 0; done = 0; cyc = 0;
        for (int i = 0; i < 2000 && !awvalid; i++) @(negedge rclk);
        if (!awvalid) return;
        addr = awaddr; len = awlen; awready = 1'b1;
        @(negedge rclk);
        awready = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (wvalid) begin
                if (abort_beat >= 0 && nb == abort_beat) begin
                    wready = 1'b0; ok = 1; return;
                end
                if (stalled && wdata !== prev) stall_err++;
                wready = (wmode == 0) ? 1'b1 : cyc[0];
                cyc++;
                if (wready) begin
                    if (nb < 16) cap[nb] = wdata;
                    nb++;
                    stalled = 0;
                    if (wlast) begin
                        lastpos = nb;
                        done = 1;
                    end
                end else begin
                    stalled = 1;
                    prev = wdata;
                end
            end
            @(negedge rclk);
        end
        wready = 1'b0;
        if (!done) return;
        for (int i = 0; i < 50 && !bready; i++) @(negedge rclk);
        if (!bready) return;
        bvalid = 1'b1; bresp = resp;
        @(negedge rclk);
        bvalid = 1'b0; bresp = 2'b00;
        ok = 1;
    endtask

    task automatic test_reset();
        rrst = 1'b0;
        #1;
        checks++;
        if ({fifo_r_en, awvalid, wvalid, bready, busy, err, wlast} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0", {fifo_r_en, awvalid, wvalid, bready, busy, err, wlast});
        end
        checks++;
        if ({awaddr, awlen, wdata} !== 72'b0) begin
            failures++; $display("FAIL reset_buses got awaddr=%h awlen=%h wdata=%h want 0", awaddr, awlen, wdata);
        end
        repeat (2) @(negedge rclk);
        rrst = 1'b1;
        @(negedge rclk);
    endtask

    task automatic test_basic();
        logic [31:0] a; logic [7:0] l; int nb, lp, se, ok;
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) push(32'h11 * i);
        collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (ok !== 1) begin failures++; $display("FAIL basic_done got=%0d want=1", ok); end
        checks++; if (a !== 32'h0) begin failures++; $display("FAIL basic_awaddr got=%h want=0", a); end
        checks++; if (l !== 8'd7) begin failures++; $display("FAIL basic_awlen got=%0d want=7", l); end
        checks++; if (nb !== 8) begin failures++; $display("FAIL basic_beats got=%0d want=8", nb); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== 32'h11 * (i + 1)) begin
                failures++; $display("FAIL basic_wdata[%0d] got=%h want=%h", i, cap[i], 32'h11 * (i + 1));
            end
        end
        checks++; if (lp !== 8) begin failures++; $display("FAIL basic_wlast_pos got=%0d want=8", lp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after_b got=%b want=0", busy); end
    endtask

    task automatic test_wready_toggle();
        logic [31:0] a; logic [7:0] l; int nb, lp, se, ok;
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        collect(1, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (ok !== 1) begin failures++; $display("FAIL toggle_done got=%0d want=1", ok); end
        checks++; if (a !== 32'h20) begin failures++; $display("FAIL toggle_awaddr got=%h want=20", a); end
        checks++; if (se !== 0) begin failures++; $display("FAIL toggle_stall_stable got=%0d changes want=0", se); end
        checks++; if (nb !== 8) begin failures++; $display("FAIL toggle_beats got=%0d want=8", nb); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== 32'hA0 + i) begin
                failures++; $display("FAIL toggle_wdata[%0d] got=%h want=%h", i, cap[i], 32'hA0 + i);
            end
        end
        checks++; if (lp !== 8) begin failures++; $display("FAIL toggle_wlast_pos got=%0d want=8", lp); end
    endtask

    task automatic test_err();
        logic [31:0] a; logic [7:0] l; int nb, lp, se, ok;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_initial got=%b want=0", err); end
        for (int i = 0; i < 8; i++) push(32'hE0 + i);
        collect(0, 2'b10, -1, a, l, nb, lp, se, ok);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err); end
        for (int i = 0; i < 8; i++) push(32'hF0 + i);
        collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (a !== 32'h60) begin failures++; $display("FAIL err_next_awaddr got=%h want=60", a); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b want=0", err); end
    endtask

    task automatic test_partial();
        logic [31:0] a; logic [7:0] l; int nb, lp, se, ok;
`ifdef FLUSH_TIMEOUT_EN
        int cyc, last_rd, aw_cyc;
        for (int i = 1; i <= 3; i++) push(32'h30 + i);
        cyc = 0; last_rd = -1; aw_cyc = -1;
        while (cyc < 1000 && aw_cyc < 0) begin
            @(negedge rclk);
            cyc++;
            if (fifo_r_en) last_rd = cyc;
            if (awvalid) aw_cyc = cyc;
        end
        checks++;
        if (aw_cyc - last_rd < 256 || aw_cyc - last_rd > 258) begin
            failures++; $display("FAIL flush_delay got=%0d want=256..258", aw_cyc - last_rd);
        end
        collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (l !== 8'd2) begin failures++; $display("FAIL flush_awlen got=%0d want=2", l); end
        checks++; if (nb !== 3) begin failures++; $display("FAIL flush_beats got=%0d want=3", nb); end
        checks++; if (lp !== 3) begin failures++; $display("FAIL flush_wlast_pos got=%0d want=3", lp); end
        checks++; if (cap[2] !== 32'h33) begin failures++; $display("FAIL flush_wdata2 got=%h want=33", cap[2]); end
        for (int i = 0; i < 8; i++) push(32'h40 + i);
        collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (a !== 32'hC) begin failures++; $display("FAIL flush_ptr_adv got=%h want=c", a); end
`else
        int seen;
        for (int i = 1; i <= 3; i++) push(32'h30 + i);
        seen = 0;
        repeat (400) begin
            @(negedge rclk);
            if (awvalid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL nopartial_aw got=%0d want=0", seen); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nopartial_busy got=%b want=1", busy); end
        for (int i = 4; i <= 8; i++) push(32'h30 + i);
        collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (a !== 32'h0) begin failures++; $display("FAIL nopartial_awaddr got=%h want=0", a); end
        checks++; if (l !== 8'd7) begin failures++; $display("FAIL nopartial_awlen got=%0d want=7", l); end
        checks++; if (nb !== 8) begin failures++; $display("FAIL nopartial_beats got=%0d want=8", nb); end
        checks++; if (cap[0] !== 32'h31 || cap[7] !== 32'h38) begin
            failures++; $display("FAIL nopartial_wdata got=%h,%h want=31,38", cap[0], cap[7]);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] a; logic [7:0] l; int nb, lp, se, ok;
        do_reset();
        for (int k = 0; k < 129; k++) begin
            for (int i = 0; i < 8; i++) push(k * 16 + i);
            collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
            checks++;
            if (a !== ((k * 32) % 4096)) begin
                failures++; $display("FAIL wrap_awaddr[%0d] got=%h want=%h", k, a, (k * 32) % 4096);
            end
        end
        checks++; if (a !== 32'h0) begin failures++; $display("FAIL wrap_last got=%h want=0", a); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a; logic [7:0] l; int nb, lp, se, ok;
        for (int i = 1; i <= 8; i++) push(32'hB0 + i);
        collect(0, 2'b00, 3, a, l, nb, lp, se, ok);
        checks++; if (ok !== 1 || wvalid !== 1'b1) begin
            failures++; $display("FAIL midrst_reach_beat4 got ok=%0d wvalid=%b want 1,1", ok, wvalid);
        end
        rrst = 1'b0;
        #1;
        checks++;
        if ({fifo_r_en, awvalid, wvalid, bready, busy, wlast} !== 6'b0) begin
            failures++; $display("FAIL midrst_ctrl got=%b want=0", {fifo_r_en, awvalid, wvalid, bready, busy, wlast});
        end
        checks++;
        if ({awaddr, awlen, wdata} !== 72'b0) begin
            failures++; $display("FAIL midrst_buses got awaddr=%h awlen=%h wdata=%h want 0", awaddr, awlen, wdata);
        end
        repeat (2) @(negedge rclk);
        rrst = 1'b1;
        @(negedge rclk);
        for (int i = 1; i <= 8; i++) push(32'hC0 + i);
        collect(0, 2'b00, -1, a, l, nb, lp, se, ok);
        checks++; if (a !== 32'h0) begin failures++; $display("FAIL midrst_restart_addr got=%h want=0", a); end
        checks++; if (cap[0] !== 32'hC1 || nb !== 8) begin
            failures++; $display("FAIL midrst_restart_data got=%h nb=%0d want=c1 nb=8", cap[0], nb);
        end
        checks++; if (mon_err !== 0) begin failures++; $display("FAIL protocol_monitor got=%0d want=0", mon_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wready_toggle();
        test_err();
        test_partial();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
